niosii_processor_pbuff_status_pio: RTL and testbench
====================================================

# niosii_processor_pbuff_status_pio

Avalon-MM slave input port with rising-edge capture and a level interrupt. It is the read-side counterpart of the pixel-buffer write-enable output port. The block samples the asynchronous `pbuff_status` lines from the pixel-buffer logic through a two-flop synchroniser and latches rising edges into a sticky capture register. The Nios II reads the register or takes an IRQ when an enabled bit is captured.

## Interface
- `DATA_WIDTH`, default 4: width of the monitored input bus and of the data, mask and capture registers (1..32).
- `clk`  in  1: system clock; all state changes on its rising edge.
- `reset_n`  in  1: reset, synchronous, active-low.
- `address`  in  2: register select. 0 = data (RO), 1 = reserved, 2 = irq mask (RW), 3 = edge capture (R/W1C).
- `chipselect`  in  1: slave selected.
- `write_n`  in  1: active-low write strobe, qualified by `chipselect`.
- `writedata`  in  32: write data; bits above `DATA_WIDTH` are ignored.
- `in_port`  in  DATA_WIDTH: asynchronous status inputs from the pixel-buffer logic.
- `readdata`  out  32: read data, zero-extended.
- `irq`  out  1: level interrupt to the CPU.

## Operation
- Synchroniser: `s1 <= in_port`, then `s2 <= s1`, then `prev <= s2`, every cycle.
- Rising edge per bit: `rise = s2 & ~prev & {DATA_WIDTH{armed}}`.
- Arm counter: 2-bit counter, cleared by reset, increments to 3 and saturates. `armed` = (count == 3).
  - This suppresses false edges while the synchroniser and `prev` fill after reset.
- Edge capture register, per bit, each cycle:
  - The bit is set if `rise`.
  - Otherwise it is cleared if the cycle is a write (`chipselect && !write_n`) to address 3 with `writedata` bit = 1.
  - Otherwise it holds.
  - If an edge and a clear hit the same bit in the same cycle, the edge wins and the bit stays 1.
  - Writing 0 to a bit has no effect.
- Irq mask register: loaded from `writedata[DATA_WIDTH-1:0]` on a write to address 2.
- Writes to addresses 0 and 1 are ignored.
- `irq` = OR-reduction of (capture & mask). It is combinational from the registers, with no extra flop.
- `readdata` is combinational and ignores `chipselect`:
  - address 0: `s2`
  - address 1: 0
  - address 2: mask
  - address 3: capture
  - all bits from `DATA_WIDTH` to 31 always read 0.
- Reads have no side effects; capture is not cleared on read.
- Reset (synchronous, `reset_n` = 0 at a rising edge) clears `s1`, `s2`, `prev`, the arm counter, mask and capture.
  - After reset: `readdata` = 0 and `irq` = 0.
  - Reset during an active edge or an active write discards both.

## Timing
- Read latency 0: `readdata` is valid in the same cycle as `address`. No wait states. Write takes effect at the edge that ends the write cycle.
- Input change before edge E0:
  - visible at address 0 after E1 (`s1` at E0, `s2` at E1);
  - capture bit set after E2;
  - `irq` high after E2 if the bit is masked in.
- Pulses shorter than one clock period may be missed. A pulse must be held for at least 2 clocks to be captured reliably.
- Mask write with a capture bit already set: `irq` rises in the cycle after the write edge. Mask write of 0: `irq` falls in the cycle after the write edge.
- W1C write clearing the last pending masked bit: `irq` low in the cycle after the write edge.
- Arm counter: no capture bit can set at the first 3 rising edges after `reset_n` returns high. An input already high during reset is therefore never captured as an edge.

## Test plan
1. Reset with `in_port` = 4'hF held:
   - read address 0 after 3 cycles → 0xF;
   - address 3 → 0x0;
   - `irq` = 0 throughout.
2. Mask = 0x1; raise `in_port[0]` before edge E0:
   - `irq` = 0 through E1, `irq` = 1 after E2;
   - address 3 reads 0x1;
   - write 0x1 to address 3 → `irq` = 0 and capture reads 0 next cycle.
3. Mask = 0x0; raise `in_port[2]`:
   - capture reads 0x4 and `irq` stays 0;
   - write mask 0x4 → `irq` = 1 one cycle later.
4. Simultaneous clear and edge: time a W1C of 0x2 to the same edge where `rise[1]` = 1 → capture bit 1 remains 1 and `irq` stays asserted.
5. Falling edges and writes to ignored addresses:
   - drop `in_port` 0xF→0x0 → capture unchanged;
   - write 0xFF to addresses 0 and 1 → data, mask and capture unchanged;
   - read address 1 → 0.
6. Reset mid-operation: capture = 0x3, mask = 0x3, `irq` = 1; pulse `reset_n` low for one edge → `irq` = 0, all registers read 0, no capture for 3 edges.

Source files
------------

// File: rtl/niosii_processor_pbuff_status_pio.sv
`default_nettype none
// ============================================================================
//  Module   : niosii_processor_pbuff_status_pio
//  Purpose  : Avalon-MM input port for the pixel-buffer status lines.
//             Two-flop synchroniser, sticky rising-edge capture (W1C),
//             interrupt mask and a level IRQ.
//  Revision : 1.0  initial release
// ============================================================================
module niosii_processor_pbuff_status_pio #(
   parameter int DATA_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [1:0]            address,
   input  logic                  chipselect,
   input  logic                  write_n,
   input  logic [31:0]           writedata,
   input  logic [DATA_WIDTH-1:0] in_port,
   output logic [31:0]           readdata,
   output logic                  irq
);

   localparam logic [1:0] c_ADDR_DATA = 2'd0;
   localparam logic [1:0] c_ADDR_RSVD = 2'd1;
   localparam logic [1:0] c_ADDR_MASK = 2'd2;
   localparam logic [1:0] c_ADDR_EDGE = 2'd3;
   localparam logic [1:0] c_ARM_FULL  = 2'd3;

   logic [DATA_WIDTH-1:0] s1_q, s2_q, prev_q;
   logic [DATA_WIDTH-1:0] mask_q, mask_d;
   logic [DATA_WIDTH-1:0] cap_q, cap_d;
   logic [1:0]            arm_q, arm_d;

   logic                  w_wr;
   logic                  w_armed;
   logic [DATA_WIDTH-1:0] w_rise;
   logic [DATA_WIDTH-1:0] w_clr;

   assign w_wr    = chipselect && !write_n;
   assign w_armed = (arm_q == c_ARM_FULL);
   // Edges are ignored until the synchroniser and prev stage hold real data.
   assign w_rise  = s2_q & ~prev_q & {DATA_WIDTH{w_armed}};
   assign w_clr   = (w_wr && address == c_ADDR_EDGE) ? writedata[DATA_WIDTH-1:0]
                                                     : '0;

   // Next-state for arm counter, mask and capture; an edge beats a clear.
   always_comb begin
      arm_d  = w_armed ? arm_q : arm_q + 2'd1;
      mask_d = mask_q;
      if (w_wr && address == c_ADDR_MASK)
         mask_d = writedata[DATA_WIDTH-1:0];
      cap_d  = w_rise | (cap_q & ~w_clr);
   end

   // Synchroniser, arm counter and register file, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
         arm_q  <= '0;
         mask_q <= '0;
         cap_q  <= '0;
      end else begin
         s1_q   <= in_port;
         s2_q   <= s1_q;
         prev_q <= s2_q;
         arm_q  <= arm_d;
         mask_q <= mask_d;
         cap_q  <= cap_d;
      end
   end

   // Zero-latency read mux, zero-extended; chipselect is not needed to read.
   always_comb begin
      readdata = '0;
      case (address)
         c_ADDR_DATA: readdata[DATA_WIDTH-1:0] = s2_q;
         c_ADDR_RSVD: readdata = '0;
         c_ADDR_MASK: readdata[DATA_WIDTH-1:0] = mask_q;
         c_ADDR_EDGE: readdata[DATA_WIDTH-1:0] = cap_q;
         default:     readdata = '0;
      endcase
   end

   assign irq = |(cap_q & mask_q);

endmodule
`default_nettype wire

// File: tb/tb_niosii_processor_pbuff_status_pio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_niosii_processor_pbuff_status_pio
//  Purpose  : Directed self-checking bench for the pixel-buffer status PIO.
//  Revision : 1.0  initial release
// ============================================================================
module tb_niosii_processor_pbuff_status_pio;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [3:0]  in_port;
   logic [31:0] readdata;
   logic        irq;

   int n_cmp = 0;
   int n_bad = 0;

   niosii_processor_pbuff_status_pio #(.DATA_WIDTH(4)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .in_port    (in_port),
      .readdata   (readdata),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle 1 time unit past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [1:0] a, input string tag, input logic [31:0] exp);
      address = a;
      #1;
      check(tag, readdata, exp);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
      tick();
      chipselect = 1'b0; write_n = 1'b1; writedata = '0;
   endtask

   initial begin
      reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
      writedata = '0; in_port = 4'hF;

      // 1: reset with inputs high
      tick();
      rd(2'd0, "rst_data", 32'h0);
      check("rst_irq", {31'b0, irq}, 32'h0);
      tick();
      reset_n = 1'b1;
      tick(); tick(); tick();
      rd(2'd0, "t1_data", 32'hF);
      rd(2'd3, "t1_cap", 32'h0);
      check("t1_irq0", {31'b0, irq}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t1_irq_hold", {31'b0, irq}, 32'h0);
      end
      rd(2'd3, "t1_cap_late", 32'h0);

      // 2: masked edge on bit 0
      in_port = 4'h0;
      tick(); tick(); tick(); tick();
      wr(2'd2, 32'h1);
      rd(2'd2, "t2_mask", 32'h1);
      in_port = 4'h1;
      tick();
      check("t2_irq_e0", {31'b0, irq}, 32'h0);
      tick();
      check("t2_irq_e1", {31'b0, irq}, 32'h0);
      tick();
      check("t2_irq_e2", {31'b0, irq}, 32'h1);
      rd(2'd3, "t2_cap", 32'h1);
      wr(2'd3, 32'h1);
      check("t2_irq_w1c", {31'b0, irq}, 32'h0);
      rd(2'd3, "t2_cap_w1c", 32'h0);

      // 3: unmasked edge on bit 2, then unmask
      wr(2'd2, 32'h0);
      in_port = 4'h5;
      tick(); tick(); tick();
      rd(2'd3, "t3_cap", 32'h4);
      check("t3_irq_off", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h4);
      check("t3_irq_on", {31'b0, irq}, 32'h1);

      // 4: W1C and edge on the same bit in the same cycle
      wr(2'd2, 32'h6);
      in_port = 4'h7;
      tick(); tick();
      wr(2'd3, 32'h2);
      rd(2'd3, "t4_cap_race", 32'h6);
      check("t4_irq_race", {31'b0, irq}, 32'h1);
      wr(2'd3, 32'h2);
      rd(2'd3, "t4_cap_clr1", 32'h4);
      wr(2'd3, 32'h4);
      rd(2'd3, "t4_cap_clr2", 32'h0);
      check("t4_irq_low", {31'b0, irq}, 32'h0);

      // 5: falling edges and ignored addresses
      in_port = 4'hF;
      tick(); tick(); tick();
      rd(2'd3, "t5_cap_b3", 32'h8);
      in_port = 4'h0;
      tick(); tick(); tick(); tick();
      rd(2'd3, "t5_cap_fall", 32'h8);
      wr(2'd0, 32'hFF);
      wr(2'd1, 32'hFF);
      rd(2'd0, "t5_data", 32'h0);
      rd(2'd2, "t5_mask", 32'h6);
      rd(2'd3, "t5_cap", 32'h8);
      rd(2'd1, "t5_rsvd", 32'h0);
      check("t5_irq", {31'b0, irq}, 32'h0);

      // 6: reset in the middle of operation
      wr(2'd3, 32'hF);
      wr(2'd2, 32'h3);
      in_port = 4'h3;
      tick(); tick(); tick();
      rd(2'd3, "t6_cap", 32'h3);
      check("t6_irq_pre", {31'b0, irq}, 32'h1);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      check("t6_irq_rst", {31'b0, irq}, 32'h0);
      rd(2'd0, "t6_data", 32'h0);
      rd(2'd2, "t6_mask", 32'h0);
      rd(2'd3, "t6_cap_rst", 32'h0);
      for (int i = 0; i < 5; i++) begin
         tick();
         rd(2'd3, "t6_cap_arm", 32'h0);
      end
      rd(2'd0, "t6_data_sync", 32'h3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
